// File: rtl/conv_lut_bitserial_seq.sv
// Bit-serial sequencer for a 4-in/2-out convolution LUT slice: walks the bit planes
// of one operand group MSB-first and shift-accumulates the LUT result.
module conv_lut_bitserial_seq #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 10,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a0,
   input  logic [DATA_W-1:0] in_a1,
   input  logic [DATA_W-1:0] in_a2,
   input  logic [DATA_W-1:0] in_a3,
   input  logic              clear,
   output logic [3:0]        lut_addr,
   input  logic [1:0]        lut_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   // state | meaning
   // IDLE  | ready for a new operand group, LUT address parked at 0
   // RUN   | one bit plane per cycle, MSB first, shift-accumulating LUT output
   // DONE  | result presented, waiting for downstream handshake

   localparam int KW = $clog2(DATA_W);

   generate
      if (DATA_W < 2 || DATA_W > 16 || ACC_W < DATA_W + 2) begin : g_bad_param
         $error("conv_lut_bitserial_seq: illegal DATA_W/ACC_W combination");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] op0, op1, op2, op3;
   logic [KW-1:0]     k;
   logic [ACC_W-1:0]  acc, acc_nxt, out_acc_r;
   logic [CNT_W-1:0]  cnt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      lut_addr  = 4'b0000;
      acc_nxt   = {acc[ACC_W-2:0], 1'b0} + ACC_W'(lut_dout);
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (!clear && in_valid) state_nxt = RUN;
         end
         RUN: begin
            lut_addr = {op3[k], op2[k], op1[k], op0[k]};
            if (clear)             state_nxt = IDLE;
            else if (k == KW'(0))  state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (clear || out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // out_acc is a separate register so it holds across the next transaction's RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         op0       <= '0;
         op1       <= '0;
         op2       <= '0;
         op3       <= '0;
         k         <= '0;
         acc       <= '0;
         out_acc_r <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!clear && in_valid) begin
                  op0 <= in_a0;
                  op1 <= in_a1;
                  op2 <= in_a2;
                  op3 <= in_a3;
                  k   <= KW'(DATA_W - 1);
                  acc <= '0;
               end
            end
            RUN: begin
               acc <= acc_nxt;
               k   <= k - KW'(1);
               if (k == KW'(0) && !clear) out_acc_r <= acc_nxt;
            end
            DONE: begin
               if (!clear && out_ready) cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign out_acc  = out_acc_r;
   assign op_count = cnt;

endmodule
